// File: rtl/cpu_cycle_irq_timer.sv
// cpu_cycle_irq_timer
// Register-programmable M2-clocked IRQ timer shared by the mapper models that
// raise IRQs from CPU cycles or emulated scanlines. It counts up or down,
// either reloads from a latch or wraps at the terminal count, and can divide
// M2 by 341/3 to approximate a scanline rate.
//
// Ports:
//   m2          - CPU M2, the only clock; all state changes on posedge
//   reset       - asynchronous, active-high; clears all state
//   wr_en       - register write strobe
//   wr_sel[2:0] - register select: 0 latch lo, 1 latch hi, 2 control,
//                 3 acknowledge, 4 counter lo, 5 counter hi, 6/7 unused
//   wr_data[7:0]- write data
//   irq         - active-low IRQ request, the inverse of irq_pending
//   irq_pending - raw pending flag for status readback
//   counter_out - current counter value
module cpu_cycle_irq_timer #(
  parameter int unsigned WIDTH         = 16,
  parameter bit          USE_PRESCALER = 1'b1
) (
  input  logic             m2,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [2:0]       wr_sel,
  input  logic [7:0]       wr_data,
  output logic             irq,
  output logic             irq_pending,
  output logic [WIDTH-1:0] counter_out
);

  localparam int unsigned PW = 9;

  localparam logic [PW-1:0] PRE_RELOAD = PW'(341);
  localparam logic [PW-1:0] PRE_STEP   = PW'(3);
  localparam logic [PW-1:0] PRE_WRAP   = PW'(338);

  localparam logic [2:0] SEL_LATCH_LO = 3'd0;
  localparam logic [2:0] SEL_LATCH_HI = 3'd1;
  localparam logic [2:0] SEL_CTRL     = 3'd2;
  localparam logic [2:0] SEL_ACK      = 3'd3;
  localparam logic [2:0] SEL_CNT_LO   = 3'd4;
  localparam logic [2:0] SEL_CNT_HI   = 3'd5;

  localparam logic [WIDTH-1:0] LO_MASK  = WIDTH'(8'hFF);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] latch_q, latch_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             enable_q, enable_d;
  logic             en_after_ack_q, en_after_ack_d;
  logic             scan_q, scan_d;
  logic             dir_up_q, dir_up_d;
  logic             auto_reload_q, auto_reload_d;
  logic             pending_q, pending_d;

  logic             tick;
  logic             terminal;
  logic             tick_blocked;
  logic             scan_active;

  // Next-state: tick generation first, register writes override afterwards.
  always_comb begin
    counter_d      = counter_q;
    latch_d        = latch_q;
    presc_d        = presc_q;
    enable_d       = enable_q;
    en_after_ack_d = en_after_ack_q;
    scan_d         = scan_q;
    dir_up_d       = dir_up_q;
    auto_reload_d  = auto_reload_q;
    pending_d      = pending_q;
    tick           = 1'b0;

    // Control and direct counter loads take priority over a tick that cycle.
    tick_blocked = wr_en && ((wr_sel == SEL_CTRL) || (wr_sel == SEL_CNT_LO) ||
                             (wr_sel == SEL_CNT_HI));
    scan_active  = USE_PRESCALER && scan_q;
    terminal     = dir_up_q ? (counter_q == ALL_ONES) : (counter_q == '0);

    // Scanline mode steps the prescaler by 3 per M2 against a period of 341,
    // yielding tick spacings of 114, 114, 113 M2 cycles.
    if (enable_q && !tick_blocked) begin
      if (scan_active) begin
        if (presc_q <= PRE_STEP) begin
          presc_d = presc_q + PRE_WRAP;
          tick    = 1'b1;
        end else begin
          presc_d = presc_q - PRE_STEP;
        end
      end else begin
        tick = 1'b1;
      end
    end

    // Counter step; a reload here uses the latch value from before any
    // same-cycle latch write.
    if (tick) begin
      if (terminal) begin
        pending_d = 1'b1;
        if (auto_reload_q) begin
          counter_d = latch_q;
        end else begin
          counter_d = dir_up_q ? '0 : ALL_ONES;
        end
      end else begin
        counter_d = dir_up_q ? (counter_q + ONE) : (counter_q - ONE);
      end
    end

    // Register writes; hi-byte writes truncate to WIDTH, so WIDTH = 8 ignores them.
    if (wr_en) begin
      case (wr_sel)
        SEL_LATCH_LO: latch_d = (latch_q & ~LO_MASK) | WIDTH'(wr_data);
        SEL_LATCH_HI: latch_d = WIDTH'({wr_data, latch_q[7:0]});
        SEL_CTRL: begin
          enable_d       = wr_data[0];
          en_after_ack_d = wr_data[1];
          scan_d         = wr_data[2];
          dir_up_d       = wr_data[3];
          auto_reload_d  = wr_data[4];
          presc_d        = PRE_RELOAD;
          pending_d      = 1'b0;
          if (wr_data[0]) begin
            counter_d = latch_q;
          end
        end
        SEL_ACK: begin
          enable_d  = en_after_ack_q;
          // A terminal tick in the same cycle keeps the flag set.
          pending_d = tick && terminal;
        end
        SEL_CNT_LO: counter_d = (counter_q & ~LO_MASK) | WIDTH'(wr_data);
        SEL_CNT_HI: counter_d = WIDTH'({wr_data, counter_q[7:0]});
        default: ;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge m2 or posedge reset) begin
    if (reset) begin
      counter_q      <= '0;
      latch_q        <= '0;
      presc_q        <= PRE_RELOAD;
      enable_q       <= 1'b0;
      en_after_ack_q <= 1'b0;
      scan_q         <= 1'b0;
      dir_up_q       <= 1'b0;
      auto_reload_q  <= 1'b0;
      pending_q      <= 1'b0;
    end else begin
      counter_q      <= counter_d;
      latch_q        <= latch_d;
      presc_q        <= presc_d;
      enable_q       <= enable_d;
      en_after_ack_q <= en_after_ack_d;
      scan_q         <= scan_d;
      dir_up_q       <= dir_up_d;
      auto_reload_q  <= auto_reload_d;
      pending_q      <= pending_d;
    end
  end

  // irq is a pure inversion of a flop, so it cannot glitch.
  assign irq         = ~pending_q;
  assign irq_pending = pending_q;
  assign counter_out = counter_q;

endmodule

// File: doc/cpu_cycle_irq_timer.md
Name: cpu_cycle_irq_timer

Overview:
- Generic CPU-cycle IRQ timer clocked by M2, shared by the mapper implementations that fire IRQs from CPU cycles or emulated scanlines.
- Mapper families covered: VRC4/VRC3-style, Sunsoft-69-style and Irem-H3001-style.
- Generalises the fixed power-on M2 down-counter into a register-programmable timer with:
  - parametrised width;
  - up or down counting;
  - auto-reload or wrap;
  - a 341/3 scanline prescaler;
  - acknowledge semantics.
- The mapper decode logic drives the write strobes and receives `irq` and the counter value.

Parameters:
- WIDTH, 16, counter/latch width in bits (8..16); bits above WIDTH-1 in written bytes are ignored.
- USE_PRESCALER, 1, 1 = scanline mode available; 0 = mode bit ignored, counter ticks every M2.

Ports:
- m2  input  1  CPU M2, sole clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- wr_en  input  1  register write strobe, sampled on posedge m2.
- wr_sel  input  3  register select (see Behaviour).
- wr_data  input  8  write data.
- irq  output  1  active-low IRQ request; 0 while irq_pending = 1, else 1.
- irq_pending  output  1  raw pending flag, for status readback.
- counter_out  output  WIDTH  current counter value.

Behaviour:
- Reset values:
  - counter = 0, latch = 0;
  - enable = 0, enable_after_ack = 0, scanline_mode = 0, dir_up = 0, auto_reload = 0;
  - irq_pending = 0, so irq = 1;
  - prescaler = 341 (9-bit).
- Register writes take effect at the posedge on which wr_en = 1:
  - sel 0: latch[7:0].
  - sel 1: latch[WIDTH-1:8]. No effect when WIDTH = 8.
  - sel 2: control.
    - bit0 = enable, bit1 = enable_after_ack, bit2 = scanline_mode, bit3 = dir_up, bit4 = auto_reload.
    - prescaler <= 341.
    - If bit0 = 1, counter <= latch.
    - irq_pending <= 0.
  - sel 3: acknowledge. irq_pending <= 0; enable <= enable_after_ack.
  - sel 4: counter[7:0] <= wr_data (direct load).
  - sel 5: counter[WIDTH-1:8] <= wr_data.
  - sel 6, 7: ignored.
- Tick generation, evaluated only while enable = 1 and no sel 2/4/5 write occurs this cycle:
  - Cycle mode (scanline_mode = 0 or USE_PRESCALER = 0): one tick every M2.
  - Scanline mode:
    - if prescaler <= 3: prescaler <= prescaler + 338 and tick;
    - else prescaler <= prescaler - 3 and no tick.
    - Resulting tick spacing from a control write is exactly 114, 114, 113 M2 cycles, repeating.
- On a tick, down mode (dir_up = 0):
  - counter == 0: irq_pending <= 1; counter <= auto_reload ? latch : all-ones (wrap).
  - otherwise: counter - 1.
- On a tick, up mode (dir_up = 1):
  - counter == all-ones: irq_pending <= 1; counter <= auto_reload ? latch : 0.
  - otherwise: counter + 1.
- While enable = 0: the counter and prescaler hold; irq_pending holds its value.
- Simultaneous events:
  - sel 2/4/5 write and tick in the same cycle: the write wins and the tick is dropped.
  - sel 3 ack and IRQ-generating tick in the same cycle: irq_pending ends at 1 (set wins). The counter still reloads or wraps, and enable <= enable_after_ack.
  - sel 0/1 write and tick in the same cycle: the tick proceeds. A reload in this cycle uses the old latch value.
- Latency:
  - irq_pending rises on the posedge of the terminal tick; irq falls on the same edge.
  - counter_out reflects writes after the writing edge.
- Reset asserted mid-count: all state returns to reset values asynchronously. No tick occurs until an enabling control write after reset is deasserted.
- irq is driven combinationally from irq_pending only (glitch-free).

Test Plan:
- Down, cycle mode, WIDTH = 16: latch = 0x0003; control = 0x11 (enable, auto_reload) -> irq = 0 on the 4th M2 after the write; counter returns to 0x0003; after sel 3 ack, irq = 1 and enable = 0.
- Up, scanline mode: latch = 0xFE, WIDTH = 8; control = 0x0D (enable, scanline, up) -> counter reaches 0xFF after 114 M2, irq asserts at M2 #228, counter reloads 0xFE only if auto_reload is set; else counter = 0x00. The next tick falls 113 M2 later.
- Down, no auto_reload: direct-load counter = 0x0001 via sel 4/5; enable -> IRQ on the 2nd tick; counter wraps to 0xFFFF and keeps counting.
- Collisions: ack on the same cycle as the terminal tick -> irq_pending stays 1. A sel 4 write on a tick cycle -> counter equals the written value, with no decrement.
- Reset pulse asserted mid-count with irq = 0 and no m2 edge -> irq = 1, counter_out = 0, and the counter stays frozen after release until the next control write.
- USE_PRESCALER = 0 with scanline bit set -> ticks every M2, identical to cycle mode.
